// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared constants, state type and forwarding helper
package pipe_hazard_ctrl_pkg;

  // ALU operand source selects
  localparam logic [1:0] FWD_RF = 2'b00;  // register file value
  localparam logic [1:0] FWD_W  = 2'b01;  // result from Writeback
  localparam logic [1:0] FWD_M  = 2'b10;  // result from Memory

  // Hazard controller state
  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } hz_state_t;

  // Operand source for one Execute-stage source register. The younger
  // producer (Memory) wins over Writeback; x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       wr_m,
    input logic [4:0] rd_m,
    input logic       wr_w,
    input logic [4:0] rd_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_M;
    end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd.sv
// rtl/pipe_hazard_ctrl_fwd.sv - combinational ALU operand forwarding unit
module pipe_fwd_unit
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs1_e,
  input  logic [4:0] rs2_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       regwrite_m,
  input  logic       regwrite_w,
  output logic [1:0] fwd_a_e,
  output logic [1:0] fwd_b_e
);

  // Pick each operand source independently; no state, so the selects stay
  // valid even while the hazard controller is held in reset.
  always_comb begin
    fwd_a_e = fwd_sel(rs1_e, regwrite_m, rd_m, regwrite_w, rd_w);
    fwd_b_e = fwd_sel(rs2_e, regwrite_m, rd_m, regwrite_w, rd_w);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush/forward control with memory-wait FSM
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic [4:0]       rd_m,
  input  logic [4:0]       rd_w,
  input  logic             load_e,
  input  logic             regwrite_m,
  input  logic             regwrite_w,
  input  logic             pc_src_e,
  input  logic             mem_req_m,
  input  logic             mem_ready,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_t         r_state;
  hz_state_t         w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_inc;
  logic              r_flush_pend;
  logic              r_mem_timeout;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_mem_miss;
  logic w_load_use;
  logic w_tmo_hit;
  logic w_mem_stall;
  logic w_stall_fd;
  logic w_flush_d;
  logic w_flush_e;
  logic w_wait_clr;
  logic w_wait_en;
  logic w_pend_set;
  logic w_pend_clr;
  logic w_tmo_set;
  logic w_stall_f;

  pipe_fwd_unit u_fwd (
    .rs1_e      (rs1_e),
    .rs2_e      (rs2_e),
    .rd_m       (rd_m),
    .rd_w       (rd_w),
    .regwrite_m (regwrite_m),
    .regwrite_w (regwrite_w),
    .fwd_a_e    (fwd_a_e),
    .fwd_b_e    (fwd_b_e)
  );

  assign w_mem_miss = mem_req_m & ~mem_ready;
  assign w_load_use = load_e & (rd_e != 5'd0) & ((rd_e == rs1_d) | (rd_e == rs2_d));
  assign w_wait_inc = r_wait_cnt + WAIT_W'(1);
  assign w_tmo_hit  = (w_wait_inc == WAIT_W'(MEM_TIMEOUT));

  // Next state and stall/flush decisions. A memory stall dominates; a taken
  // branch (live or remembered across a memory stall) dominates load-use.
  always_comb begin
    w_state_nxt = r_state;
    w_mem_stall = 1'b0;
    w_stall_fd  = 1'b0;
    w_flush_d   = 1'b0;
    w_flush_e   = 1'b0;
    w_wait_clr  = 1'b0;
    w_wait_en   = 1'b0;
    w_pend_set  = 1'b0;
    w_pend_clr  = 1'b0;
    w_tmo_set   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_mem_miss) begin
          // Stall in the very cycle the miss is seen, not one cycle later.
          w_mem_stall = 1'b1;
          w_state_nxt = ST_MEM_WAIT;
          w_wait_clr  = 1'b1;
          w_pend_set  = pc_src_e;
        end else begin
          w_pend_clr = 1'b1;
          if (pc_src_e || r_flush_pend) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
          end else if (w_load_use) begin
            w_stall_fd = 1'b1;
            w_flush_e  = 1'b1;
          end
        end
      end
      ST_MEM_WAIT: begin
        // A branch seen while waiting is replayed as a flush once running.
        w_pend_set = pc_src_e;
        if (mem_ready) begin
          // Access completes this cycle, so the pipeline may advance now.
          w_state_nxt = ST_RUN;
        end else begin
          w_mem_stall = 1'b1;
          w_wait_en   = 1'b1;
          if (w_tmo_hit) begin
            w_tmo_set   = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  assign w_stall_f = w_mem_stall | w_stall_fd;

  // Controls are forced low while reset is held so a pending stall cannot
  // freeze the pipeline through reset.
  assign stall_f     = rst_n & w_stall_f;
  assign stall_d     = rst_n & w_stall_f;
  assign stall_e     = rst_n & w_mem_stall;
  assign stall_m     = rst_n & w_mem_stall;
  assign flush_d     = rst_n & w_flush_d;
  assign flush_e     = rst_n & w_flush_e;
  assign mem_timeout = r_mem_timeout;
  assign stall_cnt   = r_stall_cnt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Memory wait counter: restarted on every entry to the wait state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (w_wait_clr) begin
      r_wait_cnt <= '0;
    end else if (w_wait_en) begin
      r_wait_cnt <= w_wait_inc;
    end
  end

  // Branch remembered across a memory stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_pend <= 1'b0;
    end else if (w_pend_set) begin
      r_flush_pend <= 1'b1;
    end else if (w_pend_clr) begin
      r_flush_pend <= 1'b0;
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_timeout <= 1'b0;
    end else if (w_tmo_set) begin
      r_mem_timeout <= 1'b1;
    end
  end

  // Saturating count of fetch-stall cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall_f && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int TMO  = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic          load_e, regwrite_m, regwrite_w, pc_src_e, mem_req_m, mem_ready;
  logic          stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
  logic [1:0]    fwd_a_e, fwd_b_e;
  logic          mem_timeout;
  logic [CW-1:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // reference model state
  bit m_wait;
  int m_wcnt;
  bit m_pend;
  bit m_tmo;
  int m_cnt;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .load_e(load_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .pc_src_e(pc_src_e), .mem_req_m(mem_req_m), .mem_ready(mem_ready),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_exp(input logic [4:0] rs);
    if (regwrite_m && rd_m != 0 && rd_m == rs) return 2'b10;
    if (regwrite_w && rd_w != 0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e}
  function automatic logic [5:0] exp_ctl();
    bit hold, lu;
    if (!rst_n) return 6'b000000;
    lu   = load_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    hold = m_wait ? !mem_ready : (mem_req_m && !mem_ready);
    if (hold) return 6'b111100;
    if (m_wait) return 6'b000000;
    if (pc_src_e || m_pend) return 6'b000011;
    if (lu) return 6'b110001;
    return 6'b000000;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [5:0] e;
    if (!rst_n) begin
      m_wait = 0; m_wcnt = 0; m_pend = 0; m_tmo = 0; m_cnt = 0;
    end else begin
      e = exp_ctl();
      if (e[5] && m_cnt < CMAX) m_cnt++;
      if (m_wait) begin
        if (pc_src_e) m_pend = 1;
        if (mem_ready) m_wait = 0;
        else begin
          m_wcnt++;
          if (m_wcnt == TMO) begin m_tmo = 1; m_wait = 0; end
        end
      end else if (mem_req_m && !mem_ready) begin
        m_wait = 1; m_wcnt = 0;
        if (pc_src_e) m_pend = 1;
      end else begin
        m_pend = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [5:0] e;
    if (chk_en) begin
      e = exp_ctl();
      chk("stall_f", stall_f, e[5]);
      chk("stall_d", stall_d, e[4]);
      chk("stall_e", stall_e, e[3]);
      chk("stall_m", stall_m, e[2]);
      chk("flush_d", flush_d, e[1]);
      chk("flush_e", flush_e, e[0]);
      chk("fwd_a_e", fwd_a_e, fwd_exp(rs1_e));
      chk("fwd_b_e", fwd_b_e, fwd_exp(rs2_e));
      chk("mem_timeout", mem_timeout, m_tmo);
      chk("stall_cnt", stall_cnt, m_cnt);
    end
  end

  task automatic idle();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    load_e = 0; regwrite_m = 0; regwrite_w = 0; pc_src_e = 0; mem_req_m = 0; mem_ready = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    int ready_bias;
    idle();
    do_reset();
    chk_en = 1;
    #1;
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_mem_timeout", mem_timeout, 0);
    chk("rst_stall_f", stall_f, 0);

    // forwarding priority and x0 exclusion
    rs1_e = 5; rd_m = 5; regwrite_m = 1; rd_w = 5; regwrite_w = 1;
    #1 chk("fwd_m_prio", fwd_a_e, 2'b10);
    rd_m = 0;
    #1 chk("fwd_w_rdm0", fwd_a_e, 2'b01);
    rd_w = 0;
    #1 chk("fwd_rf_rd0", fwd_a_e, 2'b00);
    tick(); idle();

    // load-use for exactly one cycle
    load_e = 1; rd_e = 7; rs2_d = 7;
    #1 chk("lu_stall_f", stall_f, 1);
    chk("lu_stall_d", stall_d, 1);
    chk("lu_flush_e", flush_e, 1);
    chk("lu_stall_e", stall_e, 0);
    tick(); load_e = 0;
    #1 chk("lu_after_stall_f", stall_f, 0);
    chk("lu_after_flush_e", flush_e, 0);
    // branch overrides load-use
    load_e = 1; pc_src_e = 1;
    #1 chk("br_over_lu_stall_f", stall_f, 0);
    chk("br_over_lu_flush_d", flush_d, 1);
    tick(); idle();

    // 3 miss cycles then ready
    do_reset();
    mem_req_m = 1; mem_ready = 0;
    #1 chk("miss_run_stall_m", stall_m, 1);
    tick(); #1 chk("miss_w1_stall_e", stall_e, 1);
    tick(); #1 chk("miss_w2_stall_f", stall_f, 1);
    tick(); mem_ready = 1;
    #1 chk("miss_ready_stall_f", stall_f, 0);
    tick(); mem_req_m = 0; mem_ready = 0;
    #1 chk("miss_stall_cnt", stall_cnt, 3);
    chk("miss_run_after", stall_f, 0);

    // branch during memory wait replayed after exit
    do_reset();
    mem_req_m = 1; mem_ready = 0;
    tick(); pc_src_e = 1;
    tick(); pc_src_e = 0; mem_ready = 1;
    #1 chk("pend_exit_flush_d", flush_d, 0);
    tick(); mem_req_m = 0; mem_ready = 0;
    #1 chk("pend_flush_d", flush_d, 1);
    chk("pend_flush_e", flush_e, 1);
    chk("pend_stall_f", stall_f, 0);
    tick();
    #1 chk("pend_cleared", flush_d, 0);

    // timeout after 4 wait cycles
    do_reset();
    mem_req_m = 1; mem_ready = 0;
    repeat (4) tick();
    chk("tmo_before", mem_timeout, 0);
    tick(); mem_req_m = 0;
    #1 chk("tmo_set", mem_timeout, 1);
    chk("tmo_run_stall_f", stall_f, 0);
    repeat (3) tick();
    chk("tmo_sticky", mem_timeout, 1);

    // async reset mid-wait
    mem_req_m = 1; mem_ready = 0;
    tick(); pc_src_e = 1;
    tick(); pc_src_e = 0;
    #1 rst_n = 0;
    #1 chk("arst_stall_f", stall_f, 0);
    chk("arst_stall_m", stall_m, 0);
    chk("arst_stall_cnt", stall_cnt, 0);
    chk("arst_mem_timeout", mem_timeout, 0);
    tick(); rst_n = 1; mem_req_m = 0;
    #1 chk("arst_run_stall_f", stall_f, 0);
    chk("arst_no_pend", flush_d, 0);
    tick();

    // randomized traffic against the model
    ready_bias = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) ready_bias = $urandom_range(0, 3);
      if (i % 700 == 350) begin
        #1 rst_n = 0;
        @(posedge clk);
        #1 rst_n = 1;
      end
      rs1_d = 5'($urandom_range(0, 7)); rs2_d = 5'($urandom_range(0, 7));
      rs1_e = 5'($urandom_range(0, 7)); rs2_e = 5'($urandom_range(0, 7));
      rd_e  = 5'($urandom_range(0, 7)); rd_m  = 5'($urandom_range(0, 7));
      rd_w  = 5'($urandom_range(0, 7));
      load_e     = ($urandom_range(0, 2) == 0);
      regwrite_m = $urandom_range(0, 1);
      regwrite_w = $urandom_range(0, 1);
      pc_src_e   = ($urandom_range(0, 7) == 0);
      mem_req_m  = ($urandom_range(0, 2) == 0);
      mem_ready  = (ready_bias == 0) ? 1'b0 : ($urandom_range(0, 3) < ready_bias);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: max MEM_WAIT cycles before timeout error.
REQ-002 Parameter CNT_W, default 16: width of stall performance counter.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 rs1_d, rs2_d  in  5 each  source registers of instruction in Decode.
REQ-006 rs1_e, rs2_e  in  5 each  source registers of instruction in Execute.
REQ-007 rd_e, rd_m, rd_w  in  5 each  destination registers in E/M/W.
REQ-008 load_e  in  1  instruction in Execute is a load.
REQ-009 regwrite_m, regwrite_w  in  1 each  M/W instruction writes register file.
REQ-010 pc_src_e  in  1  taken branch/jump resolved in Execute.
REQ-011 mem_req_m  in  1  Memory-stage instruction accesses data memory.
REQ-012 mem_ready  in  1  data memory completes access this cycle.
REQ-013 stall_f, stall_d, stall_e, stall_m  out  1 each  hold corresponding pipeline register.
REQ-014 flush_d, flush_e  out  1 each  zero corresponding pipeline register (bubble).
REQ-015 fwd_a_e, fwd_b_e  out  2 each  ALU operand select: 00 regfile, 10 from M, 01 from W.
REQ-016 mem_timeout  out  1  sticky error, memory wait exceeded MEM_TIMEOUT.
REQ-017 stall_cnt  out  CNT_W  saturating count of cycles with stall_f asserted.

Function
REQ-018 Forwarding SHALL be combinational: fwd_a_e=10 if regwrite_m, rd_m!=0, rd_m==rs1_e; else 01 if regwrite_w, rd_w!=0, rd_w==rs1_e; else 00; fwd_b_e identical using rs2_e; M priority over W.
REQ-019 FSM states: RUN, MEM_WAIT; reset state RUN.
REQ-020 RUN->MEM_WAIT when mem_req_m=1 and mem_ready=0; MEM_WAIT->RUN on mem_ready=1 or timeout.
REQ-021 In MEM_WAIT: stall_f, stall_d, stall_e, stall_m all 1; flush_d, flush_e 0; wait counter increments each cycle.
REQ-022 In RUN with mem_req_m=1, mem_ready=0: same stall outputs as MEM_WAIT in that cycle (no one-cycle escape).
REQ-023 Load-use in RUN: load_e=1, rd_e!=0, rd_e equals rs1_d or rs2_d -> stall_f=1, stall_d=1, flush_e=1 for exactly one cycle.
REQ-024 Branch in RUN: pc_src_e=1 -> flush_d=1, flush_e=1; branch overrides load-use (stall_f/stall_d 0 in that cycle).
REQ-025 pc_src_e=1 while stalled by memory SHALL latch flush_pend; flush_d, flush_e asserted in first RUN cycle after exit, then flush_pend cleared.
REQ-026 Wait counter reaching MEM_TIMEOUT SHALL set mem_timeout (sticky until reset) and force return to RUN next cycle.
REQ-027 Wait counter cleared on every entry to MEM_WAIT.
REQ-028 stall_cnt increments when stall_f=1, saturates at all-ones, never wraps.
REQ-029 rd=0 never triggers forwarding or load-use stall.

Reset
REQ-030 rst_n low SHALL asynchronously force: state RUN, flush_pend 0, wait counter 0, mem_timeout 0, stall_cnt 0.
REQ-031 Reset mid-MEM_WAIT SHALL drop stalls as soon as rst_n low; no pending flush survives.
REQ-032 During reset all stall/flush outputs 0; fwd outputs follow combinational rule.

Structure
REQ-033 Shared package SHALL hold fwd select constants (FWD_RF, FWD_W, FWD_M) and state enum type.
REQ-034 Forwarding logic SHALL be sub-module pipe_fwd_unit; FSM, counters, stall/flush in top.

Verification
REQ-035 rs1_e=5, rd_m=5, regwrite_m=1, rd_w=5, regwrite_w=1 -> fwd_a_e=10; rd_m=0 instead -> fwd_a_e=01.
REQ-036 load_e=1, rd_e=7, rs2_d=7, RUN -> one cycle stall_f=stall_d=flush_e=1, then all 0.
REQ-037 mem_req_m=1, mem_ready=0 for 3 cycles then 1 -> all stalls 1 for 3 cycles, RUN after; stall_cnt=3.
REQ-038 pc_src_e=1 during MEM_WAIT, mem_ready after 2 cycles -> flush_d=flush_e=1 one cycle after exit.
REQ-039 mem_ready held 0, MEM_TIMEOUT=4 -> mem_timeout=1 after 4 wait cycles, stays 1, FSM returns RUN.
REQ-040 rst_n low mid-MEM_WAIT -> stalls 0 immediately, stall_cnt 0, mem_timeout 0.
